// File: rtl/pdp8_serial_pkg.sv
// Shared definitions for the PDP-8/I console serial path (transmitter and receiver).
package pdp8_serial_pkg;

    localparam int TTY_DATA_BITS = 8;
    localparam int TTY_STOP_BITS = 2;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        START,
        DATA,
        STOP
    } ser_state_e;

    // Width of a bit counter that must reach max(a,b)-1; never narrower than 1 bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rise_det.sv
// One-register rising-edge detector; the history register resets to RST_VAL so a
// level already high at reset release does not produce a spurious edge.
module rise_det #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= RST_VAL;
        else        prev <= din;
    end

    assign rise = din & ~prev;

endmodule

// File: rtl/m707_tx.sv
// M707 teletype transmitter: shifts a loaded character out LSB-first as
// start / DATA_BITS data / STOP_BITS stop, two M452 2x-baud ticks per bit.
module m707_tx
    import pdp8_serial_pkg::*;
#(
    parameter int DATA_BITS = TTY_DATA_BITS,
    parameter int STOP_BITS = TTY_STOP_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 baud_2x,
    input  logic                 ld,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 flag_clr,
    output logic                 txd,
    output logic                 busy,
    output logic                 flag
);

    localparam int CW = cnt_width(DATA_BITS, STOP_BITS);
    localparam logic [CW-1:0] D_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] S_LAST = CW'(STOP_BITS - 1);

    typedef struct packed {
        ser_state_e           state;
        logic                 half;
        logic [CW-1:0]        bitcnt;
        logic [DATA_BITS-1:0] shreg;
        logic                 txd;
        logic                 flag;
    } tx_regs_t;

    localparam tx_regs_t REGS_RST = '{
        state:  IDLE,
        half:   1'b0,
        bitcnt: '0,
        shreg:  '0,
        txd:    1'b1,
        flag:   1'b0
    };

    tx_regs_t             r, r_n;
    logic                 tick;
    logic [DATA_BITS-1:0] sh_nxt;

    rise_det #(.RST_VAL(1'b1)) u_rise (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (baud_2x),
        .rise  (tick)
    );

    assign sh_nxt = r.shreg >> 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r <= REGS_RST;
        else        r <= r_n;
    end

    // Flag priority: clear first, load clears, end-of-frame set overrides both.
    always_comb begin
        r_n = r;
        if (flag_clr) r_n.flag = 1'b0;
        case (r.state)
            IDLE: begin
                r_n.txd = 1'b1;
                if (ld) begin
                    r_n.shreg = data;
                    r_n.flag  = 1'b0;
                    r_n.state = ARM;
                end
            end
            ARM: begin
                if (tick) begin
                    r_n.state = START;
                    r_n.txd   = 1'b0;
                    r_n.half  = 1'b0;
                end
            end
            START, DATA, STOP: begin
                if (tick) begin
                    if (!r.half) begin
                        r_n.half = 1'b1;
                    end else begin
                        r_n.half = 1'b0;
                        case (r.state)
                            START: begin
                                r_n.state  = DATA;
                                r_n.txd    = r.shreg[0];
                                r_n.bitcnt = '0;
                            end
                            DATA: begin
                                r_n.shreg = sh_nxt;
                                if (r.bitcnt == D_LAST) begin
                                    r_n.state  = STOP;
                                    r_n.txd    = 1'b1;
                                    r_n.bitcnt = '0;
                                end else begin
                                    r_n.bitcnt = r.bitcnt + CW'(1);
                                    r_n.txd    = sh_nxt[0];
                                end
                            end
                            default: begin
                                if (r.bitcnt == S_LAST) begin
                                    r_n.state = IDLE;
                                    r_n.flag  = 1'b1;
                                end else begin
                                    r_n.bitcnt = r.bitcnt + CW'(1);
                                end
                            end
                        endcase
                    end
                end
            end
            default: r_n.state = IDLE;
        endcase
    end

    assign txd  = r.txd;
    assign busy = (r.state != IDLE);
    assign flag = r.flag;

endmodule

// File: tb/tb_m707_tx.sv
// Bench for m707_tx: loads push expected frames into a queue; a monitor pops one
// per start edge and checks every bit centre, stop bits and the flag timing.
module tb_m707_tx;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       baud_2x  = 1'b1;
    logic       ld       = 1'b0;
    logic       flag_clr = 1'b0;
    logic [7:0] data     = 8'h00;
    logic       txd, busy, flag;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int flag_rises = 0;
    bit baud_en = 1'b0;

    typedef struct {
        logic [7:0] d;
        bit         abort;
        int         ld_cyc;
    } exp_t;

    exp_t exp_q[$];

    m707_tx #(.DATA_BITS(8), .STOP_BITS(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_2x  (baud_2x),
        .ld       (ld),
        .data     (data),
        .flag_clr (flag_clr),
        .txd      (txd),
        .busy     (busy),
        .flag     (flag)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // baud_2x period 20 clk; held high while disabled
    initial begin : baud_gen
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!baud_en) begin
                baud_2x = 1'b1;
                cnt = 0;
            end else begin
                cnt++;
                if (cnt == 10) begin
                    cnt = 0;
                    baud_2x = ~baud_2x;
                end
            end
        end
    end

    initial begin : flag_count
        bit pf;
        pf = 1'b0;
        forever begin
            @(negedge clk);
            if (flag && !pf) flag_rises++;
            pf = flag;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Called just after a negedge; ld is seen by the DUT on the next posedge.
    task automatic send(input logic [7:0] dv, input bit abort, input bit push);
        ld   = 1'b1;
        data = dv;
        if (push) exp_q.push_back('{d: dv, abort: abort, ld_cyc: cyc});
        @(negedge clk);
        ld = 1'b0;
    endtask

    task automatic wait_flag(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (flag) begin
                seen = 1'b1;
                break;
            end
        end
        chk({nm, "_flag_timeout"}, 32'(seen), 1);
    endtask

    initial begin : monitor
        bit   pt;
        exp_t e;
        int   t0;
        pt = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && pt && !txd) begin
                t0 = cyc;
                if (exp_q.size() == 0) begin
                    chk("spurious_frame", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("start_latency", 32'((t0 - e.ld_cyc >= 2) && (t0 - e.ld_cyc <= 21)), 1);
                    if (e.abort) begin
                        for (int i = 0; i < 1000 && rst_n; i++) @(negedge clk);
                        for (int i = 0; i < 1000 && !rst_n; i++) @(negedge clk);
                    end else begin
                        repeat (20) @(negedge clk);
                        chk("start_bit", 32'(txd), 0);
                        for (int k = 0; k < 8; k++) begin
                            repeat (40) @(negedge clk);
                            chk($sformatf("data_bit%0d_of_%02h", k, e.d), 32'(txd), 32'(e.d[k]));
                        end
                        for (int k = 0; k < 2; k++) begin
                            repeat (40) @(negedge clk);
                            chk($sformatf("stop_bit%0d", k), 32'(txd), 1);
                        end
                        repeat (19) @(negedge clk);
                        chk("busy_flag_at_439", {30'd0, busy, flag}, 32'b10);
                        @(negedge clk);
                        chk("busy_flag_at_440", {30'd0, busy, flag}, 32'b01);
                    end
                end
            end
            pt = txd;
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not complete, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit ok;
        bit seen;
        int fr0;

        // reset with baud_2x held high
        repeat (5) @(negedge clk);
        chk("reset_txd",  32'(txd),  1);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_flag", 32'(flag), 0);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || flag !== 1'b0) ok = 1'b0;
        end
        chk("idle_200", 32'(ok), 1);

        baud_en = 1'b1;
        repeat (50) @(negedge clk);

        // basic frame
        send(8'hA5, 1'b0, 1'b1);
        chk("busy_after_ld", 32'(busy), 1);
        wait_flag("a5");
        repeat (30) @(negedge clk);

        // load while busy is ignored
        fr0 = flag_rises;
        send(8'hA5, 1'b0, 1'b1);
        repeat (150) @(negedge clk);
        chk("busy_mid_frame", 32'(busy), 1);
        send(8'h41, 1'b0, 1'b0);
        wait_flag("a5_again");
        repeat (600) @(negedge clk);
        chk("flag_set_once", 32'(flag_rises - fr0), 1);
        chk("flag_kept", 32'(flag), 1);

        // flag_clr coinciding with end of frame
        send(8'h3C, 1'b0, 1'b1);
        chk("ld_clears_flag", 32'(flag), 0);
        repeat (5) @(negedge clk);
        flag_clr = 1'b1;
        wait_flag("3c");
        flag_clr = 1'b0;
        chk("set_beats_clr", 32'(flag), 1);
        @(negedge clk);
        chk("flag_hold", 32'(flag), 1);
        flag_clr = 1'b1;
        @(negedge clk);
        flag_clr = 1'b0;
        chk("flag_clr", 32'(flag), 0);
        repeat (30) @(negedge clk);

        // async reset in data bit 3 (all-zero char so txd is low there)
        send(8'h00, 1'b1, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (txd === 1'b0) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("abort_start_seen", 32'(seen), 1);
        repeat (180) @(negedge clk);
        chk("pre_reset_txd",  32'(txd),  0);
        chk("pre_reset_busy", 32'(busy), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_txd",  32'(txd),  1);
        chk("async_reset_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        ok = 1'b1;
        repeat (600) begin
            @(negedge clk);
            if (txd !== 1'b1 || busy !== 1'b0 || flag !== 1'b0) ok = 1'b0;
        end
        chk("post_reset_quiet", 32'(ok), 1);

        // back-to-back frames; second load also carries flag_clr
        send(8'h5A, 1'b0, 1'b1);
        wait_flag("5a");
        flag_clr = 1'b1;
        send(8'hC3, 1'b0, 1'b1);
        flag_clr = 1'b0;
        chk("ld_with_clr_flag", 32'(flag), 0);
        chk("b2b_busy", 32'(busy), 1);
        wait_flag("c3");
        repeat (30) @(negedge clk);
        chk("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
